layer_mem_arbiter: RTL

- Shares one single-port 4096x16 layer SRAM between two requesters.
- Port 0 is the convolution writer/reader and port 1 is the pooling reader/writer, so both engines can run concurrently instead of in strict phases.
- Arbitration is round-robin with a bounded burst per owner.
- The memory command is registered, and read data is returned to the requester that issued it, tagged with rvalid.

---
 rtl/layer_mem_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter: shares one single-port layer SRAM between two requesters.
//   Port 0 (convolution) and port 1 (pooling) each present req/we/addr/wdata and
//   receive a combinational gnt. The selected access is registered onto the SRAM
//   command bus (mem_ceb/mem_web/mem_A/mem_D) one cycle after the grant. Read data
//   comes back from mem_Q two cycles after the grant on the issuing port only,
//   qualified by rvalid.
//   Arbitration is round-robin with a bounded burst: an owner keeps the memory
//   for at most MAX_BURST consecutive grants while the other port is waiting.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   rN_req/we/addr/wdata      requester N access (held until granted)
//   rN_gnt                    requester N access accepted this cycle
//   rN_rvalid/rdata           requester N read return
//   mem_ceb/web/A/D, mem_Q    SRAM command (ceb active-high, web active-low) and data
module layer_mem_arbiter #(
  parameter int unsigned AW        = 12,
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_ceb,
  output logic          mem_web,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_D,
  input  logic [DW-1:0] mem_Q
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic          owner_q, owner_d;
  logic [3:0]    burst_q, burst_d;

  logic          ceb_q, ceb_d;
  logic          web_q, web_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  // Read return pipeline: stage 1 tracks the cycle the SRAM command is issued,
  // stage 2 is the cycle mem_Q carries the data.
  logic          rd_vld_q, rd_vld_d;
  logic          rd_port_q, rd_port_d;
  logic          rv0_q, rv0_d;
  logic          rv1_q, rv1_d;

  logic          gnt0, gnt1, gnt_any, sel_port;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Grant decode. Reset suppresses grants so nothing is accepted while held.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    sel_port = 1'b0;
    if (!rst) begin
      if (r0_req && r1_req) begin
        // Owner keeps the memory until its burst allowance is used up.
        sel_port = (burst_q < MaxBurst) ? owner_q : ~owner_q;
        gnt0     = ~sel_port;
        gnt1     = sel_port;
      end else begin
        gnt0 = r0_req;
        gnt1 = r1_req;
      end
    end
  end

  assign gnt_any   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? r1_we    : r0_we;
  assign sel_addr  = gnt1 ? r1_addr  : r0_addr;
  assign sel_wdata = gnt1 ? r1_wdata : r0_wdata;

  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    if (gnt_any) begin
      if (gnt1 == owner_q) begin
        burst_d = (burst_q >= MaxBurst) ? MaxBurst : burst_q + 4'd1;
      end else begin
        owner_d = gnt1;
        burst_d = 4'd1;
      end
    end
  end

  always_comb begin
    ceb_d     = gnt_any;
    web_d     = gnt_any ? ~sel_we : 1'b1;
    addr_d    = gnt_any ? sel_addr : addr_q;
    wdata_d   = gnt_any ? sel_wdata : wdata_q;
    rd_vld_d  = gnt_any & ~sel_we;
    rd_port_d = gnt1;
    rv0_d     = rd_vld_q & ~rd_port_q;
    rv1_d     = rd_vld_q & rd_port_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q   <= 1'b0;
      burst_q   <= 4'd0;
      ceb_q     <= 1'b0;
      web_q     <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_vld_q  <= 1'b0;
      rd_port_q <= 1'b0;
      rv0_q     <= 1'b0;
      rv1_q     <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      ceb_q     <= ceb_d;
      web_q     <= web_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_vld_q  <= rd_vld_d;
      rd_port_q <= rd_port_d;
      rv0_q     <= rv0_d;
      rv1_q     <= rv1_d;
    end
  end

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rvalid = rv0_q;
  assign r1_rvalid = rv1_q;
  // rdata is zeroed outside its valid cycle so idle outputs stay quiet.
  assign r0_rdata  = rv0_q ? mem_Q : '0;
  assign r1_rdata  = rv1_q ? mem_Q : '0;
  assign mem_ceb   = ceb_q;
  assign mem_web   = web_q;
  assign mem_A     = addr_q;
  assign mem_D     = wdata_q;

endmodule
